if_pc_unit: RTL and testbench

- IF-stage next-PC generator and dynamic branch predictor for the 5-stage Minisys-1A pipeline.
- Owns the PC register. Predicts conditional branches in IF with a 2-bit-counter BHT.
- Consumes ID-stage branch resolution (nBranch, J, JR, rs) and redirects fetch when ID disagrees with the prediction.
- Generates IF_Flush for the IF/ID register.

---
 rtl/if_pc_unit_pkg.sv | 33 +++
 rtl/if_pc_unit_bht.sv | 36 +++
 rtl/if_pc_unit.sv | 108 ++++++++++
 tb/tb_if_pc_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/if_pc_unit_pkg.sv
// Shared constants for the Minisys-1A IF-stage PC unit: branch opcodes,
// 2-bit counter encodings and the reset defaults.
package if_pc_unit_pkg;

  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_REGIMM = 6'b000001;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_cnt_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [1:0]  CNT_INIT_DEFAULT = WT;

  // Saturating 2-bit counter step toward the resolved direction.
  function automatic logic [1:0] cnt_sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != ST) nxt = cnt + 2'd1;
    end else begin
      if (cnt != SNT) nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/if_pc_unit_bht.sv
// Branch history table: 2^BHT_BITS two-bit saturating counters with an
// async-reset fill, a combinational read port (IF) and a clocked update port (ID).
module bht_2bit
  import if_pc_unit_pkg::*;
#(
  parameter int         BHT_BITS = 4,
  parameter logic [1:0] CNT_INIT = CNT_INIT_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [BHT_BITS-1:0] rd_idx_i,
  output logic [1:0]          rd_cnt_o,
  input  logic                wr_en_i,
  input  logic [BHT_BITS-1:0] wr_idx_i,
  input  logic                wr_taken_i
);

  localparam int N_ENTRIES = 1 << BHT_BITS;

  logic [1:0] cnt_q [N_ENTRIES];
  logic [1:0] wr_cnt_d;

  assign wr_cnt_d = cnt_sat_update(cnt_q[wr_idx_i], wr_taken_i);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_ENTRIES; i++) cnt_q[i] <= CNT_INIT;
    end else if (wr_en_i) begin
      cnt_q[wr_idx_i] <= wr_cnt_d;
    end
  end

  // Read sees the pre-update value when IF and ID hit the same entry.
  assign rd_cnt_o = cnt_q[rd_idx_i];

endmodule

// File: rtl/if_pc_unit.sv
// IF-stage next-PC generator with a 2-bit BHT predictor; resolves the
// prediction against the ID-stage branch outcome and redirects/flushes fetch.
module if_pc_unit
  import if_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          BHT_BITS = 4,
  parameter logic [1:0]  CNT_INIT = CNT_INIT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ID_stall,
  input  logic [31:0] IF_instruction,
  input  logic        IFBranch,
  input  logic        ID_Branch,
  input  logic        nBranch,
  input  logic        J,
  input  logic        JR,
  input  logic [25:0] ID_jaddr,
  input  logic [31:0] rs,
  output logic [31:0] PC,
  output logic [31:0] PC_plus4,
  output logic        IF_Flush,
  output logic        pred_taken,
  output logic        mispredict
);

  logic [31:0]         pc_q, pc_d;
  logic                id_valid_q;
  logic                id_pred_q;
  logic [31:0]         id_pc4_q;
  logic [31:0]         id_tgt_q;
  logic [BHT_BITS-1:0] id_idx_q;

  logic [31:0]         pc_plus4;
  logic [31:0]         br_tgt;
  logic [31:0]         j_tgt;
  logic [BHT_BITS-1:0] if_idx;
  logic [1:0]          if_cnt;
  logic                id_taken;
  logic                id_resolve;
  logic                redirect;
  logic                unused_instr_hi;

  assign pc_plus4 = pc_q + 32'd4;
  assign br_tgt   = pc_plus4 + {{14{IF_instruction[15]}}, IF_instruction[15:0], 2'b00};
  assign if_idx   = pc_q[BHT_BITS+1:2];

  // The opcode is decoded upstream into IFBranch; only the offset is needed here.
  assign unused_instr_hi = ^IF_instruction[31:16];

  bht_2bit #(
    .BHT_BITS (BHT_BITS),
    .CNT_INIT (CNT_INIT)
  ) u_bht (
    .clock      (clock),
    .reset      (reset),
    .rd_idx_i   (if_idx),
    .rd_cnt_o   (if_cnt),
    .wr_en_i    (id_resolve),
    .wr_idx_i   (id_idx_q),
    .wr_taken_i (id_taken)
  );

  assign pred_taken = IFBranch & if_cnt[1];

  assign id_taken   = ID_Branch & ~nBranch;
  assign id_resolve = ~ID_stall & ID_Branch & id_valid_q;
  assign mispredict = id_resolve & (id_taken != id_pred_q);
  assign j_tgt      = {id_pc4_q[31:28], ID_jaddr, 2'b00};
  assign redirect   = ~ID_stall & (JR | J | mispredict);
  assign IF_Flush   = redirect;

  always_comb begin
    pc_d = pc_plus4;
    if (ID_stall)        pc_d = pc_q;
    else if (JR)         pc_d = rs;
    else if (J)          pc_d = j_tgt;
    else if (mispredict) pc_d = id_taken ? id_tgt_q : id_pc4_q;
    else if (pred_taken) pc_d = br_tgt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  // A redirect squashes the IF instruction, so the slot becomes a bubble.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_valid_q <= 1'b0;
      id_pred_q  <= 1'b0;
      id_pc4_q   <= 32'd0;
      id_tgt_q   <= 32'd0;
      id_idx_q   <= '0;
    end else if (!ID_stall) begin
      id_valid_q <= IFBranch & ~redirect;
      id_pred_q  <= pred_taken;
      id_pc4_q   <= pc_plus4;
      id_tgt_q   <= br_tgt;
      id_idx_q   <= if_idx;
    end
  end

  assign PC       = pc_q;
  assign PC_plus4 = pc_plus4;

endmodule

// File: tb/tb_if_pc_unit.sv
// Directed scoreboard bench for if_pc_unit: each cycle's stimulus pushes the
// hand-computed outputs, a negedge monitor pops and compares them.
module tb_if_pc_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        ID_stall;
  logic [31:0] IF_instruction;
  logic        IFBranch;
  logic        ID_Branch;
  logic        nBranch;
  logic        J;
  logic        JR;
  logic [25:0] ID_jaddr;
  logic [31:0] rs;
  logic [31:0] PC;
  logic [31:0] PC_plus4;
  logic        IF_Flush;
  logic        pred_taken;
  logic        mispredict;

  if_pc_unit dut (
    .clock          (clock),
    .reset          (reset),
    .ID_stall       (ID_stall),
    .IF_instruction (IF_instruction),
    .IFBranch       (IFBranch),
    .ID_Branch      (ID_Branch),
    .nBranch        (nBranch),
    .J              (J),
    .JR             (JR),
    .ID_jaddr       (ID_jaddr),
    .rs             (rs),
    .PC             (PC),
    .PC_plus4       (PC_plus4),
    .IF_Flush       (IF_Flush),
    .pred_taken     (pred_taken),
    .mispredict     (mispredict)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        flush;
    logic        pred;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] BEQ3  = 32'h1022_0003; // beq, offset +3
  localparam logic [31:0] BEQM1 = 32'h1022_FFFF; // beq, offset -1 (branch to self)

  task automatic cyc(input string nm, input logic rst_v, input logic stall,
                     input logic ifbr, input logic [31:0] instr,
                     input logic idbr, input logic nbr, input logic j, input logic jr,
                     input logic [25:0] jaddr, input logic [31:0] rs_v,
                     input logic [31:0] e_pc, input logic e_fl, input logic e_pr,
                     input logic e_mi);
    exp_t e;
    reset          = rst_v;
    ID_stall       = stall;
    IFBranch       = ifbr;
    IF_instruction = instr;
    ID_Branch      = idbr;
    nBranch        = nbr;
    J              = j;
    JR             = jr;
    ID_jaddr       = jaddr;
    rs             = rs_v;
    e.name = nm; e.pc = e_pc; e.flush = e_fl; e.pred = e_pr; e.mis = e_mi;
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      if (PC !== e.pc) begin
        n_bad++; $display("FAIL %s PC got %h want %h", e.name, PC, e.pc);
      end
      n_vec++;
      if (PC_plus4 !== e.pc + 32'd4) begin
        n_bad++; $display("FAIL %s PC_plus4 got %h want %h", e.name, PC_plus4, e.pc + 32'd4);
      end
      n_vec++;
      if (IF_Flush !== e.flush) begin
        n_bad++; $display("FAIL %s IF_Flush got %b want %b", e.name, IF_Flush, e.flush);
      end
      n_vec++;
      if (pred_taken !== e.pred) begin
        n_bad++; $display("FAIL %s pred_taken got %b want %b", e.name, pred_taken, e.pred);
      end
      n_vec++;
      if (mispredict !== e.mis) begin
        n_bad++; $display("FAIL %s mispredict got %b want %b", e.name, mispredict, e.mis);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; ID_stall = 0; IFBranch = 0; IF_instruction = NOP;
    ID_Branch = 0; nBranch = 0; J = 0; JR = 0; ID_jaddr = '0; rs = '0;
    @(posedge clock); #1;
    //   name          rst stl ifb instr  idb nb  j   jr  jaddr  rs            exp_pc        fl pr mi
    cyc("rst_hold",    1,  0,  0,  NOP,   0,  0,  0,  0,  26'd0, 32'd0,        32'h0000_0000, 0, 0, 0);
    cyc("rst_hold2",   1,  0,  0,  NOP,   0,  0,  0,  0,  26'd0, 32'd0,        32'h0000_0000, 0, 0, 0);
    cyc("rel_pc0",     0,  0,  0,  NOP,   0,  0,  0,  0,  26'd0, 32'd0,        32'h0000_0000, 0, 0, 0);
    cyc("step_pc4",    0,  0,  0,  NOP,   0,  0,  0,  0,  26'd0, 32'd0,        32'h0000_0004, 0, 0, 0);
    cyc("step_pc8",    0,  0,  0,  NOP,   0,  0,  0,  0,  26'd0, 32'd0,        32'h0000_0008, 0, 0, 0);
    cyc("rst_mid",     1,  0,  0,  NOP,   0,  0,  0,  0,  26'd0, 32'd0,        32'h0000_0000, 0, 0, 0);
    cyc("rst_rel",     0,  0,  0,  NOP,   0,  0,  0,  0,  26'd0, 32'd0,        32'h0000_0000, 0, 0, 0);
    cyc("walk4",       0,  0,  0,  NOP,   0,  0,  0,  0,  26'd0, 32'd0,        32'h0000_0004, 0, 0, 0);
    cyc("walk8",       0,  0,  0,  NOP,   0,  0,  0,  0,  26'd0, 32'd0,        32'h0000_0008, 0, 0, 0);
    cyc("walkC",       0,  0,  0,  NOP,   0,  0,  0,  0,  26'd0, 32'd0,        32'h0000_000C, 0, 0, 0);
    // predicted-taken miss: counter[4]=2
    cyc("pt_fetch",    0,  0,  1,  BEQ3,  0,  0,  0,  0,  26'd0, 32'd0,        32'h0000_0010, 0, 1, 0);
    cyc("pt_miss",     0,  0,  0,  NOP,   1,  1,  0,  0,  26'd0, 32'd0,        32'h0000_0020, 1, 0, 1);
    cyc("bubble_br",   0,  0,  0,  NOP,   1,  0,  0,  0,  26'd0, 32'd0,        32'h0000_0014, 0, 0, 0);
    cyc("j_back10",    0,  0,  0,  NOP,   0,  0,  1,  0,  26'd4, 32'd0,        32'h0000_0018, 1, 0, 0);
    // predicted-not-taken miss: counter[4]=1
    cyc("pnt_fetch",   0,  0,  1,  BEQ3,  0,  0,  0,  0,  26'd0, 32'd0,        32'h0000_0010, 0, 0, 0);
    cyc("pnt_miss",    0,  0,  0,  NOP,   1,  0,  0,  0,  26'd0, 32'd0,        32'h0000_0014, 1, 0, 1);
    cyc("after_pnt",   0,  0,  0,  NOP,   0,  0,  0,  0,  26'd0, 32'd0,        32'h0000_0020, 0, 0, 0);
    cyc("j_back10b",   0,  0,  0,  NOP,   0,  0,  1,  0,  26'd4, 32'd0,        32'h0000_0024, 1, 0, 0);
    // self-loop branch: counter[4] 2 -> 3 -> 3 -> 3
    cyc("loop_fetch",  0,  0,  1,  BEQM1, 0,  0,  0,  0,  26'd0, 32'd0,        32'h0000_0010, 0, 1, 0);
    cyc("loop_ok1",    0,  0,  1,  BEQM1, 1,  0,  0,  0,  26'd0, 32'd0,        32'h0000_0010, 0, 1, 0);
    cyc("loop_ok2",    0,  0,  1,  BEQM1, 1,  0,  0,  0,  26'd0, 32'd0,        32'h0000_0010, 0, 1, 0);
    cyc("loop_sat",    0,  0,  1,  BEQM1, 1,  0,  0,  0,  26'd0, 32'd0,        32'h0000_0010, 0, 1, 0);
    cyc("loop_exit",   0,  0,  0,  NOP,   1,  1,  0,  0,  26'd0, 32'd0,        32'h0000_0010, 1, 0, 1);
    cyc("post_exit",   0,  0,  0,  NOP,   0,  0,  0,  0,  26'd0, 32'd0,        32'h0000_0014, 0, 0, 0);
    // J held by stall, then taken
    cyc("j_stall1",    0,  1,  0,  NOP,   0,  0,  1,  0,  26'h40, 32'd0,       32'h0000_0018, 0, 0, 0);
    cyc("j_stall2",    0,  1,  0,  NOP,   0,  0,  1,  0,  26'h40, 32'd0,       32'h0000_0018, 0, 0, 0);
    cyc("j_go",        0,  0,  0,  NOP,   0,  0,  1,  0,  26'h40, 32'd0,       32'h0000_0018, 1, 0, 0);
    cyc("j_target",    0,  0,  0,  NOP,   0,  0,  0,  0,  26'd0, 32'd0,        32'h0000_0100, 0, 0, 0);
    // JR beats J
    cyc("jr_over_j",   0,  0,  0,  NOP,   0,  0,  1,  1,  26'd4, 32'h0000_0400, 32'h0000_0104, 1, 0, 0);
    cyc("jr_fetch",    0,  0,  1,  BEQ3,  0,  0,  0,  0,  26'd0, 32'd0,        32'h0000_0400, 0, 1, 0);
    // mispredict held off by stall, retried after
    cyc("mis_stall",   0,  1,  0,  NOP,   1,  1,  0,  0,  26'd0, 32'd0,        32'h0000_0410, 0, 0, 0);
    cyc("mis_retry",   0,  0,  0,  NOP,   1,  1,  0,  0,  26'd0, 32'd0,        32'h0000_0410, 1, 0, 1);
    cyc("jr_back400",  0,  0,  0,  NOP,   0,  0,  0,  1,  26'd0, 32'h0000_0400, 32'h0000_0404, 1, 0, 0);
    cyc("cnt0_is1",    0,  0,  1,  BEQ3,  0,  0,  0,  0,  26'd0, 32'd0,        32'h0000_0400, 0, 0, 0);
    cyc("nt_correct",  0,  0,  0,  NOP,   1,  1,  0,  0,  26'd0, 32'd0,        32'h0000_0404, 0, 0, 0);
    // wrap and unaligned JR target
    cyc("jr_top",      0,  0,  0,  NOP,   0,  0,  0,  1,  26'd0, 32'hFFFF_FFFC, 32'h0000_0408, 1, 0, 0);
    cyc("wrap_top",    0,  0,  0,  NOP,   0,  0,  0,  0,  26'd0, 32'd0,        32'hFFFF_FFFC, 0, 0, 0);
    cyc("jr_odd",      0,  0,  0,  NOP,   0,  0,  0,  1,  26'd0, 32'h0000_0203, 32'h0000_0000, 1, 0, 0);
    cyc("odd_pc",      0,  0,  0,  NOP,   0,  0,  0,  0,  26'd0, 32'd0,        32'h0000_0203, 0, 0, 0);
    repeat (2) @(posedge clock);
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
